mac_sequencer: RTL
==================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; reset asserts immediately and releases synchronously to `clock`.
REQ-002 Ports SHALL be as follows:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  write one operand pair into the buffer.
- `load_addr`  in  3  buffer entry index, 0..7.
- `load_a`  in  8  signed operand A.
- `load_b`  in  9  signed operand B.
- `start`  in  1  begin a dot product; level-sampled.
- `length`  in  4  number of pairs to use, N; legal range 1..8.
- `product`  out  17  signed product, registered; feeds the downstream accumulator.
- `start_accumulate`  out  1  registered; high with the first product of a run.
- `sum_valid`  out  1  one-cycle pulse: the downstream 20-bit sum is final.
- `busy`  out  1  high in every state except IDLE.
- `len_err`  out  1  one-cycle pulse: `start` was rejected because `length` was illegal.

Function
REQ-003 The block SHALL hold an 8-entry buffer of {A[7:0], B[8:0]} operand pairs.
REQ-004 In IDLE, a high `load_en` SHALL write `load_a`/`load_b` to entry `load_addr` at the clock edge.
REQ-005 While `busy` is high, `load_en` SHALL be ignored and the buffer SHALL remain unchanged.
REQ-006 The FSM SHALL have exactly four states: IDLE, RUN, WAIT, DONE.
REQ-007 IDLE → RUN SHALL occur at edge E0 when `start` is high and 1 <= `length` <= 8; N and the index (0) are latched at E0.
REQ-008 If `start` is high in IDLE with `length` = 0 or > 8, the state SHALL stay IDLE and `len_err` SHALL be high for the following cycle.
REQ-009 In RUN with index i, the next edge SHALL register `product` = signed A[i] × signed B[i], full 17-bit result, no truncation or saturation.
REQ-010 On that same edge, `start_accumulate` SHALL be registered as (i == 0).
REQ-011 The index SHALL increment by 1 per RUN cycle; RUN SHALL last exactly N cycles.
REQ-012 After the last RUN cycle, product p(N-1) SHALL be presented during the WAIT cycle (state entered at edge E_N).
REQ-013 At edge E_{N+1} the state SHALL be DONE, `sum_valid` SHALL be 1, and `product` and `start_accumulate` SHALL be 0.
REQ-014 DONE SHALL return to IDLE after one cycle.
REQ-015 Outside product-presenting cycles, `product` SHALL be 0 and `start_accumulate` SHALL be 0, so the downstream sum holds its value.
REQ-016 `start` while `busy` is high SHALL be ignored, with no queuing and no `len_err`.
REQ-017 `start` is first re-accepted in the IDLE cycle after DONE; back-to-back runs SHALL have a period of N+3 cycles.
REQ-018 If `load_en` and a legal `start` coincide in IDLE, the write SHALL complete and the run SHALL use post-write buffer contents (RUN reads the buffer from E0 onward).

Reset
REQ-019 On `reset`, the FSM SHALL go to IDLE, the index and latched N SHALL clear, and all buffer entries SHALL be 0.
REQ-020 On `reset`, `product`, `start_accumulate`, `sum_valid`, `busy` and `len_err` SHALL all be 0.
REQ-021 Reset mid-run SHALL abort the run with no `sum_valid` pulse for it.
REQ-022 The first `start` accepted after reset release SHALL behave as if from a fresh IDLE.

Structure
REQ-023 A shared package SHALL hold: A_W=8, B_W=9, P_W=17, DEPTH=8, LEN_W=4, and the FSM state enum.
REQ-024 The operand buffer SHALL be a sub-module `operand_regfile` with one write port and one combinational read port, gated by `busy`.
REQ-025 The FSM, index counter and product register SHALL reside in `mac_sequencer`.

Verification
REQ-026 Load entries 0..2 with (3,4), (-5,6), (7,-8); start with N=3, accumulator attached. Required: `product` = 12, -30, -56 on three consecutive cycles, `start_accumulate` high only with 12, and `sum_valid` at E4 with sum = -74.
REQ-027 Load all 8 entries with (-128,-256); start with N=8. Required: every product = 32768, and sum = 262144 on the `sum_valid` cycle, which occurs 9 edges after E0.
REQ-028 Start with `length`=0, then with `length`=9. Required: `len_err` pulses once each, `busy` stays 0, `product` stays 0.
REQ-029 Raise `start` and `load_en` (to entry 0) during RUN. Required: both are ignored, the run result is unchanged, and a following run still sees the original entry 0.
REQ-030 Assert `reset` at the second RUN cycle of an N=5 run. Required: all outputs are 0 immediately, no `sum_valid` pulse appears, and a fresh N=1 run (2,3) gives sum 6 at E2.
REQ-031 Hold `start` high continuously with N=2. Required: `sum_valid` pulses every 5 cycles, and each run's sum restarts from its own first product.

Source files
------------

// File: rtl/mac_sequencer_pkg.sv
// Shared widths, FSM state encoding and length check for the MAC sequencer.
package mac_sequencer_pkg;

    localparam int A_W   = 8;
    localparam int B_W   = 9;
    localparam int P_W   = 17;
    localparam int DEPTH = 8;
    localparam int LEN_W = 4;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        DONE
    } state_t;

    // A run length is usable only when it names at least one and at most DEPTH entries.
    function automatic logic length_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(DEPTH));
    endfunction

endpackage

// File: rtl/operand_regfile.sv
// Eight-entry {A, B} operand buffer: one write port locked out while busy,
// one combinational read port.
module operand_regfile
    import mac_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  busy,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic signed [A_W-1:0] wr_a,
    input  logic signed [B_W-1:0] wr_b,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic signed [A_W-1:0] rd_a,
    output logic signed [B_W-1:0] rd_b
);

    logic signed [A_W-1:0] mem_a [DEPTH];
    logic signed [B_W-1:0] mem_b [DEPTH];

    // NOTE: the buffer is reset, so a run launched before any load reads zeros, never X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (wr_en && !busy) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    assign rd_a = mem_a[rd_addr];
    assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/mac_sequencer.sv
// Steps through N buffered operand pairs, presenting one signed product per cycle
// to a downstream accumulator, then flags the final sum.
module mac_sequencer
    import mac_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_addr,
    input  logic signed [A_W-1:0] load_a,
    input  logic signed [B_W-1:0] load_b,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    output logic signed [P_W-1:0] product,
    output logic                  start_accumulate,
    output logic                  sum_valid,
    output logic                  busy,
    output logic                  len_err
);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [LEN_W-1:0]      len_q;
    logic signed [A_W-1:0] rd_a;
    logic signed [B_W-1:0] rd_b;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic                  last;

    assign busy  = (state != IDLE);
    assign a_ext = {{(P_W-A_W){rd_a[A_W-1]}}, rd_a};
    assign b_ext = {{(P_W-B_W){rd_b[B_W-1]}}, rd_b};
    assign last  = ({1'b0, idx} == len_q - LEN_W'(1));

    operand_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .busy    (busy),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_a    (load_a),
        .wr_b    (load_b),
        .rd_addr (idx),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // NOTE: pulse outputs default to 0 at the top of the clocked block, so every
    // branch only states when they are high; all state uses non-blocking updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            len_q            <= '0;
            product          <= '0;
            start_accumulate <= 1'b0;
            sum_valid        <= 1'b0;
            len_err          <= 1'b0;
        end else begin
            product          <= '0;
            start_accumulate <= 1'b0;
            sum_valid        <= 1'b0;
            len_err          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length_ok(length)) begin
                            state <= RUN;
                            idx   <= '0;
                            len_q <= length;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Product is exact: 8x9 signed always fits in 17 bits.
                    product          <= a_ext * b_ext;
                    start_accumulate <= (idx == '0);
                    if (last) begin
                        state <= WAIT;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                WAIT: begin
                    state     <= DONE;
                    sum_valid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
